// File: rtl/btn_pll_phase_stepper_if.sv
// rtl/btn_pll_phase_stepper_if.sv - button inputs and ECP5 PLL dynamic phase-shift outputs
interface btn_pll_phase_stepper_if #(
  parameter int C_phase_bits = 8
);
  logic                    inc;
  logic                    dec;
  logic                    phasedir;
  logic                    phasestep;
  logic                    phaseloadreg;
  logic [C_phase_bits-1:0] phase;
  logic                    busy;

  modport master (
    output inc, dec,
    input  phasedir, phasestep, phaseloadreg, phase, busy
  );

  modport slave (
    input  inc, dec,
    output phasedir, phasestep, phaseloadreg, phase, busy
  );
endinterface

// File: rtl/btn_pll_phase_stepper.sv
// rtl/btn_pll_phase_stepper.sv - debounced inc/dec buttons to one PLL phase step per press
// Optional autorepeat while one button is held: BTN_PHASE_AUTOREPEAT_EN
module btn_pll_phase_stepper #(
  parameter int C_debounce_bits = 16,
  parameter int C_step_cycles   = 4,
  parameter int C_phase_bits    = 8,
  parameter int C_repeat_bits   = 22
) (
  input  logic                      clk,
  input  logic                      reset,
  btn_pll_phase_stepper_if.slave    bus
);
  localparam int SW = $clog2(C_step_cycles + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETDIR = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_GUARD  = 2'd3;

  // index 0 = inc, index 1 = dec
  logic [1:0]                 sync1, sync2, deb, deb_d, press;
  logic [C_debounce_bits-1:0] db_cnt [2];
  logic [1:0]                 state;
  logic [SW-1:0]              step_cnt;
  logic                       phasedir_q, phasestep_q;
  logic [C_phase_bits-1:0]    phase_q;
  logic                       ev_inc, ev_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_d  <= '0;
      press  <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= {bus.dec, bus.inc};
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (&db_cnt[i]) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef BTN_PHASE_AUTOREPEAT_EN
  logic [C_repeat_bits-1:0] rep_cnt;
  logic                     rep_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rep_cnt <= '0;
    else if (deb[0] ^ deb[1])
      rep_cnt <= rep_cnt + 1'b1;
    else
      rep_cnt <= '0;
  end

  assign rep_evt = (deb[0] ^ deb[1]) && (&rep_cnt);
  assign ev_inc  = press[0] | (rep_evt & deb[0]);
  assign ev_dec  = press[1] | (rep_evt & deb[1]);
`else
  assign ev_inc = press[0];
  assign ev_dec = press[1];
`endif

  // phasedir is loaded on the IDLE exit so it is already valid throughout SETDIR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      phasedir_q  <= 1'b0;
      phasestep_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_inc ^ ev_dec) begin
            phasedir_q <= ev_dec;
            state      <= S_SETDIR;
          end
        end
        S_SETDIR: begin
          phasestep_q <= 1'b1;
          step_cnt    <= '0;
          phase_q     <= phasedir_q ? phase_q - 1'b1 : phase_q + 1'b1;
          state       <= S_STEP;
        end
        S_STEP: begin
          if (step_cnt == SW'(C_step_cycles - 1)) begin
            phasestep_q <= 1'b0;
            step_cnt    <= '0;
            state       <= S_GUARD;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: begin
          if (step_cnt == SW'(C_step_cycles - 1)) begin
            step_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.phasedir     = phasedir_q;
  assign bus.phasestep    = phasestep_q;
  assign bus.phaseloadreg = 1'b0;
  assign bus.phase        = phase_q;
  assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_btn_pll_phase_stepper.sv
// tb/tb_btn_pll_phase_stepper.sv - directed self-checking bench for btn_pll_phase_stepper
module tb_btn_pll_phase_stepper;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int   pulse_total = 0;
  int   cur_width = 0;
  int   last_width = 0;
  logic last_dir = 1'b0;
  logic prev_step = 1'b0;

  btn_pll_phase_stepper_if #(.C_phase_bits(4)) bus ();

  btn_pll_phase_stepper #(
    .C_debounce_bits(3),
    .C_step_cycles(2),
    .C_phase_bits(4),
    .C_repeat_bits(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.phasestep && !prev_step) begin
      pulse_total <= pulse_total + 1;
      cur_width   <= 1;
      last_dir    <= bus.phasedir;
    end else if (bus.phasestep) begin
      cur_width <= cur_width + 1;
    end else if (prev_step) begin
      last_width <= cur_width;
    end
    prev_step <= bus.phasestep;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic press(input logic is_dec, input int hold);
    if (is_dec) bus.dec = 1'b1; else bus.inc = 1'b1;
    cycles(hold);
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    cycles(30);
  endtask

  task automatic test_reset();
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    reset = 1'b1;
    cycles(3);
    checks++; if (bus.phasestep !== 1'b0) begin errors++; $display("FAIL rst_phasestep got=%b exp=0", bus.phasestep); end
    checks++; if (bus.phasedir !== 1'b0) begin errors++; $display("FAIL rst_phasedir got=%b exp=0", bus.phasedir); end
    checks++; if (bus.phase !== 4'h0) begin errors++; $display("FAIL rst_phase got=%h exp=0", bus.phase); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.phaseloadreg !== 1'b0) begin errors++; $display("FAIL rst_loadreg got=%b exp=0", bus.phaseloadreg); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int p0 = pulse_total;
    cycles(100);
    checks++; if (pulse_total - p0 !== 0) begin errors++; $display("FAIL idle_pulses got=%0d exp=0", pulse_total - p0); end
    checks++; if (bus.phase !== 4'h0) begin errors++; $display("FAIL idle_phase got=%h exp=0", bus.phase); end
    checks++; if (bus.phaseloadreg !== 1'b0) begin errors++; $display("FAIL idle_loadreg got=%b exp=0", bus.phaseloadreg); end
  endtask

  task automatic test_inc_press();
    int p0 = pulse_total;
    press(1'b0, 40);
    checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL inc_pulses got=%0d exp=1", pulse_total - p0); end
    checks++; if (last_width !== 2) begin errors++; $display("FAIL inc_width got=%0d exp=2", last_width); end
    checks++; if (last_dir !== 1'b0) begin errors++; $display("FAIL inc_dir got=%b exp=0", last_dir); end
    checks++; if (bus.phase !== 4'h1) begin errors++; $display("FAIL inc_phase got=%h exp=1", bus.phase); end
  endtask

  task automatic test_glitch();
    int p0 = pulse_total;
    press(1'b0, 4);
    checks++; if (pulse_total - p0 !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", pulse_total - p0); end
    checks++; if (bus.phase !== 4'h1) begin errors++; $display("FAIL glitch_phase got=%h exp=1", bus.phase); end
  endtask

  task automatic test_wrap();
    int p0;
    do_reset();
    p0 = pulse_total;
    press(1'b1, 20);
    checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL dec_pulses got=%0d exp=1", pulse_total - p0); end
    checks++; if (last_dir !== 1'b1) begin errors++; $display("FAIL dec_dir got=%b exp=1", last_dir); end
    checks++; if (bus.phase !== 4'hF) begin errors++; $display("FAIL dec_wrap got=%h exp=f", bus.phase); end
    do_reset();
    p0 = pulse_total;
    for (int i = 0; i < 16; i++) press(1'b0, 20);
    checks++; if (pulse_total - p0 !== 16) begin errors++; $display("FAIL inc16_pulses got=%0d exp=16", pulse_total - p0); end
    checks++; if (bus.phase !== 4'h0) begin errors++; $display("FAIL inc16_wrap got=%h exp=0", bus.phase); end
  endtask

  task automatic test_simultaneous_busy();
    int p0 = pulse_total;
    bus.inc = 1'b1;
    bus.dec = 1'b1;
    cycles(20);
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    cycles(30);
    checks++; if (pulse_total - p0 !== 0) begin errors++; $display("FAIL both_pulses got=%0d exp=0", pulse_total - p0); end
    p0 = pulse_total;
    bus.inc = 1'b1;
    cycles(2);
    bus.dec = 1'b1;
    cycles(20);
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    cycles(30);
    checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL busy_pulses got=%0d exp=1", pulse_total - p0); end
    checks++; if (last_dir !== 1'b0) begin errors++; $display("FAIL busy_dir got=%b exp=0", last_dir); end
    checks++; if (bus.phase !== 4'h1) begin errors++; $display("FAIL busy_phase got=%h exp=1", bus.phase); end
  endtask

  task automatic test_reset_mid_step();
    int budget = 0;
    bus.inc = 1'b1;
    while (!bus.phasestep && budget < 100) begin
      cycles(1);
      budget++;
    end
    checks++; if (bus.phasestep !== 1'b1) begin errors++; $display("FAIL midstep_reach got=%b exp=1", bus.phasestep); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.phasestep !== 1'b0) begin errors++; $display("FAIL midstep_drop got=%b exp=0", bus.phasestep); end
    checks++; if (bus.phase !== 4'h0) begin errors++; $display("FAIL midstep_phase got=%h exp=0", bus.phase); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midstep_busy got=%b exp=0", bus.busy); end
    bus.inc = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(5);
  endtask

  task automatic test_autorepeat();
    int p0;
    int exp_n;
    do_reset();
    p0 = pulse_total;
`ifdef BTN_PHASE_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    press(1'b0, 300);
    checks++; if (pulse_total - p0 !== exp_n) begin errors++; $display("FAIL hold_pulses got=%0d exp=%0d", pulse_total - p0, exp_n); end
    checks++; if (bus.phase !== 4'(exp_n)) begin errors++; $display("FAIL hold_phase got=%h exp=%h", bus.phase, 4'(exp_n)); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_inc_press();
    test_glitch();
    test_wrap();
    test_simultaneous_busy();
    test_reset_mid_step();
    test_autorepeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
